and_path_exerciser: RTL and testbench

- On-chip stimulus/response controller for the twelve 6-input AND path variants (paths a–d × electrical effort h=1, 5, 20).
- Drives the shared 6-bit input bus `a` into the DUT array and receives the selected `y`.
- SWEEP mode: exhaustive functional check of all 64 input patterns.
- OSC mode: DUT closed in an external inverting ring; counts oscillation edges over a fixed window for delay characterisation.

---
 rtl/and_tst_pkg.sv | 41 ++++
 rtl/and_path_exerciser_if.sv | 24 ++
 rtl/and_tst_sync.sv | 28 ++
 rtl/and_path_exerciser.sv | 192 +++++++++++++++++++
 tb/tb_and_path_exerciser.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/and_tst_pkg.sv
// Shared constants for the 6-input AND path exerciser: FSM state codes,
// DUT array size and index map, oscillation drive pattern, sync depth.
package and_tst_pkg;

  localparam int unsigned N_DUT       = 12;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PAT_W       = 6;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned ST_W        = 3;

  localparam logic [PAT_W-1:0] OSC_PATTERN = 6'b111110;
  localparam logic [PAT_W-1:0] PAT_LAST    = 6'h3F;

  // FSM state codes
  localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
  localparam logic [ST_W-1:0] ST_SW_DRIVE  = 3'd1;
  localparam logic [ST_W-1:0] ST_SW_SAMPLE = 3'd2;
  localparam logic [ST_W-1:0] ST_OSC_ARM   = 3'd3;
  localparam logic [ST_W-1:0] ST_OSC_RUN   = 3'd4;
  localparam logic [ST_W-1:0] ST_DONE      = 3'd5;

  // DUT index = path*3 + h_index (h1/h5/h20 = 0/1/2)
  localparam int unsigned AND_PA_H1  = 0;
  localparam int unsigned AND_PA_H5  = 1;
  localparam int unsigned AND_PA_H20 = 2;
  localparam int unsigned AND_PB_H1  = 3;
  localparam int unsigned AND_PB_H5  = 4;
  localparam int unsigned AND_PB_H20 = 5;
  localparam int unsigned AND_PC_H1  = 6;
  localparam int unsigned AND_PC_H5  = 7;
  localparam int unsigned AND_PC_H20 = 8;
  localparam int unsigned AND_PD_H1  = 9;
  localparam int unsigned AND_PD_H5  = 10;
  localparam int unsigned AND_PD_H20 = 11;

  // Out-of-range selects fall back to index 0
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] s);
    return (32'(s) >= N_DUT) ? SEL_W'(0) : s;
  endfunction

endpackage

// File: rtl/and_path_exerciser_if.sv
// Control/result interface of the exerciser.
//   master: start, mode, sel, window -> ; <- busy, done, pass, fail_pat, count
//   slave : the exerciser side
interface and_path_exerciser_if #(
  parameter int unsigned WIN_W = 16,
  parameter int unsigned CNT_W = 16
);
  import and_tst_pkg::*;

  logic             start;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [WIN_W-1:0] window;
  logic             busy;
  logic             done;
  logic             pass;
  logic [PAT_W-1:0] fail_pat;
  logic [CNT_W-1:0] count;

  modport master (output start, mode, sel, window,
                  input  busy, done, pass, fail_pat, count);
  modport slave  (input  start, mode, sel, window,
                  output busy, done, pass, fail_pat, count);
endinterface

// File: rtl/and_tst_sync.sv
// Multi-flop synchroniser plus one extra flop for rising-edge detection.
//   clk, rst : clock, synchronous active-high reset
//   d        : asynchronous input
//   y_s      : synchronised level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
module and_tst_sync
  import and_tst_pkg::*;
#(
  parameter int unsigned STAGES = SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic y_s,
  output logic rise
);

  logic [STAGES:0] sh_q;

  always_ff @(posedge clk) begin
    if (rst) sh_q <= '0;
    else     sh_q <= {sh_q[STAGES-1:0], d};
  end

  assign y_s  = sh_q[STAGES-1];
  assign rise = sh_q[STAGES-1] & ~sh_q[STAGES];

endmodule

// File: rtl/and_path_exerciser.sv
// Stimulus/response controller for the AND path variants.
// SWEEP: walks a = 0..63, compares synchronised y against &a.
// OSC  : holds a = 111110 with the ring closed and counts y rising edges.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/mode/sel/window in, busy/done/pass/fail_pat/count out
//   dut_y    : asynchronous outputs of all DUT variants
//   drv_a    : shared DUT input bus
//   osc_en   : closes the external ring around the selected DUT
module and_path_exerciser
  import and_tst_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned WIN_W  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  and_path_exerciser_if.slave  bus,
  input  logic [N_DUT-1:0]     dut_y,
  output logic [PAT_W-1:0]     drv_a,
  output logic                 osc_en
);

  localparam int unsigned SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  logic [ST_W-1:0]  state_q,    state_n;
  logic [PAT_W-1:0] pat_q,      pat_n;
  logic [SET_W-1:0] set_q,      set_n;
  logic [WIN_W-1:0] win_q,      win_n;
  logic [1:0]       flush_q,    flush_n;
  logic             fail_q,     fail_n;
  logic [SEL_W-1:0] sel_q,      sel_n;
  logic [WIN_W-1:0] window_q,   window_n;
  logic [PAT_W-1:0] drv_a_q,    drv_a_n;
  logic             osc_en_q,   osc_en_n;
  logic             busy_q,     busy_n;
  logic             done_q,     done_n;
  logic             pass_q,     pass_n;
  logic [PAT_W-1:0] fail_pat_q, fail_pat_n;
  logic [CNT_W-1:0] count_q,    count_n;

  logic y_s, rise, mismatch;

  and_tst_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (dut_y[sel_q]),
    .y_s  (y_s),
    .rise (rise)
  );

  // Only the all-ones pattern should drive y high
  assign mismatch = y_s ^ (pat_q == PAT_LAST);

  // State and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pat_q      <= '0;
      set_q      <= '0;
      win_q      <= '0;
      flush_q    <= '0;
      fail_q     <= 1'b0;
      sel_q      <= '0;
      window_q   <= '0;
      drv_a_q    <= '0;
      osc_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_pat_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_n;
      pat_q      <= pat_n;
      set_q      <= set_n;
      win_q      <= win_n;
      flush_q    <= flush_n;
      fail_q     <= fail_n;
      sel_q      <= sel_n;
      window_q   <= window_n;
      drv_a_q    <= drv_a_n;
      osc_en_q   <= osc_en_n;
      busy_q     <= busy_n;
      done_q     <= done_n;
      pass_q     <= pass_n;
      fail_pat_q <= fail_pat_n;
      count_q    <= count_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n    = state_q;
    pat_n      = pat_q;
    set_n      = set_q;
    win_n      = win_q;
    flush_n    = flush_q;
    fail_n     = fail_q;
    sel_n      = sel_q;
    window_n   = window_q;
    drv_a_n    = drv_a_q;
    osc_en_n   = osc_en_q;
    busy_n     = busy_q;
    done_n     = done_q;
    pass_n     = pass_q;
    fail_pat_n = fail_pat_q;
    count_n    = count_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          sel_n      = clamp_sel(bus.sel);
          window_n   = bus.window;
          done_n     = 1'b0;
          pass_n     = 1'b0;
          fail_pat_n = '0;
          count_n    = '0;
          busy_n     = 1'b1;
          fail_n     = 1'b0;
          pat_n      = '0;
          set_n      = '0;
          flush_n    = '0;
          if (bus.mode) begin
            state_n  = ST_OSC_ARM;
            drv_a_n  = OSC_PATTERN;
            osc_en_n = 1'b1;
          end else begin
            state_n  = ST_SW_DRIVE;
            drv_a_n  = '0;
          end
        end
      end

      ST_SW_DRIVE: begin
        if (set_q == SET_W'(SETTLE - 1)) state_n = ST_SW_SAMPLE;
        else                             set_n   = set_q + SET_W'(1);
      end

      ST_SW_SAMPLE: begin
        if (mismatch && !fail_q) begin
          fail_n     = 1'b1;
          fail_pat_n = pat_q;
        end
        if (pat_q == PAT_LAST) begin
          state_n = ST_DONE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          pass_n  = ~(fail_q | mismatch);
          drv_a_n = '0;
        end else begin
          state_n = ST_SW_DRIVE;
          pat_n   = pat_q + PAT_W'(1);
          drv_a_n = pat_q + PAT_W'(1);
          set_n   = '0;
        end
      end

      ST_OSC_ARM: begin
        // Hold for the synchroniser to flush stale edges
        win_n = window_q;
        if (flush_q == 2'd2) state_n = ST_OSC_RUN;
        else                 flush_n = flush_q + 2'd1;
      end

      ST_OSC_RUN: begin
        if (rise && (count_q != '1)) count_n = count_q + CNT_W'(1);
        // Window of 0 or 1 both give a single run cycle
        if (win_q <= WIN_W'(1)) begin
          state_n  = ST_DONE;
          osc_en_n = 1'b0;
          drv_a_n  = '0;
          done_n   = 1'b1;
          busy_n   = 1'b0;
        end else begin
          win_n = win_q - WIN_W'(1);
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  assign drv_a        = drv_a_q;
  assign osc_en       = osc_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.fail_pat = fail_pat_q;
  assign bus.count    = count_q;

endmodule

// File: tb/tb_and_path_exerciser.sv
// Directed + randomised bench for and_path_exerciser with a behavioural
// DUT-array model (AND plus per-variant fault masks, or a square-wave source).
module tb_and_path_exerciser;
  import and_tst_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  and_path_exerciser_if #(.WIN_W(16), .CNT_W(16)) bus0 ();
  and_path_exerciser_if #(.WIN_W(16), .CNT_W(4))  bus1 ();

  logic [N_DUT-1:0] dut_y0, dut_y1;
  logic [PAT_W-1:0] drv_a0, drv_a1;
  logic             osc_en0, osc_en1;

  and_path_exerciser #(.SETTLE(4), .WIN_W(16), .CNT_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .dut_y(dut_y0), .drv_a(drv_a0), .osc_en(osc_en0));

  and_path_exerciser #(.SETTLE(4), .WIN_W(16), .CNT_W(4)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .dut_y(dut_y1), .drv_a(drv_a1), .osc_en(osc_en1));

  // DUT array model: bit p of fmask[i] inverts variant i's output for a == p
  logic [63:0] fmask [N_DUT];
  logic        osc_on = 1'b0;
  int          osc_idx = 0;
  int          osc_half = 5;
  int          osc_cnt = 0;
  logic        osc_y = 1'b0;
  int          sat_cnt = 0;
  logic        sat_y = 1'b0;

  always @(posedge clk) begin
    if (osc_cnt >= osc_half - 1) begin osc_cnt <= 0; osc_y <= ~osc_y; end
    else osc_cnt <= osc_cnt + 1;
    if (sat_cnt >= 1) begin sat_cnt <= 0; sat_y <= ~sat_y; end
    else sat_cnt <= sat_cnt + 1;
  end

  always_comb begin
    for (int i = 0; i < N_DUT; i++) dut_y0[i] = (&drv_a0) ^ fmask[i][drv_a0];
    if (osc_on) begin
      dut_y0 = '0;
      dut_y0[osc_idx] = osc_y;
    end
  end
  assign dut_y1 = sat_y ? '1 : '0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  function automatic int idx_of(input int s);
    return (s >= N_DUT) ? 0 : s;
  endfunction

  function automatic int first_set(input logic [63:0] m);
    for (int p = 0; p < 64; p++) if (m[p]) return p;
    return -1;
  endfunction

  // Returns at the falling edge just after the accepting rising edge
  task automatic pulse_start(input logic m, input int s, input int w);
    @(negedge clk);
    bus0.start  = 1'b1;
    bus0.mode   = m;
    bus0.sel    = SEL_W'(s);
    bus0.window = 16'(w);
    @(negedge clk);
    bus0.start  = 1'b0;
  endtask

  // n = rising edges since the accepting edge; hi = cycles with osc_en set
  task automatic wait_done(input int budget, input int inject_at,
                           output int n, output int hi, output logic drv_ok);
    n = 0; hi = 0; drv_ok = 1'b1;
    while (!bus0.done && n < budget) begin
      if (osc_en0) begin
        hi++;
        if (drv_a0 !== OSC_PATTERN) drv_ok = 1'b0;
      end
      bus0.start = (n == inject_at);
      bus0.mode  = 1'b1;
      @(negedge clk);
      n++;
    end
    bus0.start = 1'b0;
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N_DUT; i++) fmask[i] = '0;
  endtask

  task automatic run_sweep(input string tag, input int s, input int inject_at);
    int n, hi, fs;
    logic ok;
    fs = first_set(fmask[idx_of(s)]);
    pulse_start(1'b0, s, 0);
    wait_done(1000, inject_at, n, hi, ok);
    chk({tag, "_lat"},  n, 320);
    chk({tag, "_done"}, bus0.done, 1);
    chk({tag, "_busy"}, bus0.busy, 0);
    chk({tag, "_pass"}, bus0.pass, (fs < 0) ? 1 : 0);
    chk({tag, "_fpat"}, bus0.fail_pat, (fs < 0) ? 0 : fs);
    chk({tag, "_drva"}, drv_a0, 0);
    chk({tag, "_osc"},  hi, 0);
  endtask

  task automatic run_osc(input string tag, input int s, input int w, input int half);
    int n, hi, period;
    logic ok;
    period   = 2 * half;
    osc_half = half;
    osc_idx  = idx_of(s);
    osc_on   = 1'b1;
    pulse_start(1'b1, s, w);
    wait_done(70000, -1, n, hi, ok);
    chk({tag, "_lat"},   n, 3 + ((w == 0) ? 1 : w));
    chk({tag, "_oscen"}, hi, 3 + ((w == 0) ? 1 : w));
    chk({tag, "_drva"},  ok, 1);
    chk({tag, "_oscoff"}, osc_en0, 0);
    chk_rng({tag, "_cnt"}, int'(bus0.count), (w / period) - 1, (w / period) + 1);
    osc_on = 1'b0;
  endtask

  initial begin
    int n, hi;
    logic ok;
    clear_faults();
    bus0.start = 1'b0; bus0.mode = 1'b0; bus0.sel = '0; bus0.window = '0;
    bus1.start = 1'b0; bus1.mode = 1'b0; bus1.sel = '0; bus1.window = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_busy", bus0.busy, 0);
    chk("rst_done", bus0.done, 0);
    chk("rst_drva", drv_a0, 0);
    chk("rst_osc",  osc_en0, 0);
    chk("rst_cnt",  bus0.count, 0);
    rst = 1'b0;

    // Good DUT sweep, then faulty variant 2
    run_sweep("sw_good", 5, -1);
    for (int p = 0; p < 64; p++)
      fmask[2][p] = ((p == 'h2A) || (p >= 'h30)) ^ (p == 63);
    run_sweep("sw_fault", 2, -1);
    clear_faults();

    // sel beyond the array clamps to index 0
    fmask[0][17] = 1'b1;
    run_sweep("sw_clamp", 13, -1);
    clear_faults();

    // start while busy is ignored
    run_sweep("sw_ignore", 3, 100);

    // Reset 50 cycles into a sweep
    pulse_start(1'b0, 4, 0);
    repeat (49) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_busy", bus0.busy, 0);
    chk("mid_done", bus0.done, 0);
    chk("mid_drva", drv_a0, 0);
    chk("mid_pass", bus0.pass, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_idle", bus0.busy, 0);

    // Oscillation count
    run_osc("osc100", 7, 100, 5);
    run_osc("osc0", 7, 0, 1000);

    // Randomised sweeps with sparse fault masks
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N_DUT; i++) begin
        fmask[i] = '0;
        if ($urandom_range(0, 1) == 0) begin
          fmask[i][$urandom_range(0, 63)] = 1'b1;
          fmask[i][$urandom_range(0, 63)] = 1'b1;
        end
      end
      run_sweep($sformatf("rsw%0d", r), int'($urandom_range(0, 15)), -1);
    end
    clear_faults();

    // Randomised oscillation runs
    for (int r = 0; r < 4; r++)
      run_osc($sformatf("rosc%0d", r), int'($urandom_range(0, 15)),
              int'($urandom_range(20, 200)), int'($urandom_range(2, 8)));

    // Saturating counter (4-bit) on the second instance
    @(negedge clk);
    bus1.start = 1'b1; bus1.mode = 1'b1; bus1.sel = 4'd3; bus1.window = 16'd200;
    @(negedge clk);
    bus1.start = 1'b0;
    n = 0; hi = 0; ok = 1'b1;
    while (!bus1.done && n < 1000) begin
      if (osc_en1 && drv_a1 !== OSC_PATTERN) ok = 1'b0;
      @(negedge clk);
      n++;
    end
    chk("sat_lat",  n, 203);
    chk("sat_drva", ok, 1);
    chk("sat_cnt",  bus1.count, 15);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
